// File: rtl/wb_arb2_slv1.sv
// ----------------------------------------------------------------------------
// wb_arb2_slv1 : two-master, one-slave Wishbone B4 arbiter with window decode
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_arb2_slv1 #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int BLW      = 10,
   parameter int SLV_SIZE = 262144
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [DW-1:0]     m0_wbd_dat_i,
   input  logic [AW-1:0]     m0_wbd_adr_i,
   input  logic [DW/8-1:0]   m0_wbd_sel_i,
   input  logic              m0_wbd_we_i,
   input  logic              m0_wbd_cyc_i,
   input  logic              m0_wbd_stb_i,
   output logic [DW-1:0]     m0_wbd_dat_o,
   output logic              m0_wbd_ack_o,
   output logic              m0_wbd_lack_o,
   output logic              m0_wbd_err_o,

   input  logic [DW-1:0]     m1_wbd_dat_i,
   input  logic [AW-1:0]     m1_wbd_adr_i,
   input  logic [DW/8-1:0]   m1_wbd_sel_i,
   input  logic [BLW-1:0]    m1_wbd_bl_i,
   input  logic              m1_wbd_bry_i,
   input  logic              m1_wbd_we_i,
   input  logic              m1_wbd_cyc_i,
   input  logic              m1_wbd_stb_i,
   output logic [DW-1:0]     m1_wbd_dat_o,
   output logic              m1_wbd_ack_o,
   output logic              m1_wbd_lack_o,
   output logic              m1_wbd_err_o,

   input  logic [DW-1:0]     s_wbd_dat_i,
   input  logic              s_wbd_ack_i,
   input  logic              s_wbd_lack_i,
   output logic [DW-1:0]     s_wbd_dat_o,
   output logic [AW-1:0]     s_wbd_adr_o,
   output logic [DW/8-1:0]   s_wbd_sel_o,
   output logic [BLW-1:0]    s_wbd_bl_o,
   output logic              s_wbd_bry_o,
   output logic              s_wbd_we_o,
   output logic              s_wbd_cyc_o,
   output logic              s_wbd_stb_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   // One extra bit keeps the window compare exact even if SLV_SIZE == 2**AW.
   localparam logic [AW:0]    C_SLV_LIMIT = (AW+1)'(SLV_SIZE);
   localparam logic [BLW-1:0] C_BL_ONE    = {{(BLW-1){1'b0}}, 1'b1};

   state_t state_q, state_d;

   logic m0_bad, m1_bad;

   assign m0_bad = ({1'b0, m0_wbd_adr_i} >= C_SLV_LIMIT);
   assign m1_bad = ({1'b0, m1_wbd_adr_i} >= C_SLV_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant is held until the owner drops cyc; hand-over goes straight across.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (m0_wbd_cyc_i)      state_d = G0;
            else if (m1_wbd_cyc_i) state_d = G1;
         end
         G0: begin
            if (!m0_wbd_cyc_i)     state_d = m1_wbd_cyc_i ? G1 : IDLE;
         end
         G1: begin
            if (!m1_wbd_cyc_i)     state_d = m0_wbd_cyc_i ? G0 : IDLE;
         end
         default:                  state_d = IDLE;
      endcase
   end

   always_comb begin
      s_wbd_dat_o   = '0;
      s_wbd_adr_o   = '0;
      s_wbd_sel_o   = '0;
      s_wbd_bl_o    = '0;
      s_wbd_bry_o   = 1'b0;
      s_wbd_we_o    = 1'b0;
      s_wbd_cyc_o   = 1'b0;
      s_wbd_stb_o   = 1'b0;
      m0_wbd_dat_o  = '0;
      m0_wbd_ack_o  = 1'b0;
      m0_wbd_lack_o = 1'b0;
      m0_wbd_err_o  = 1'b0;
      m1_wbd_dat_o  = '0;
      m1_wbd_ack_o  = 1'b0;
      m1_wbd_lack_o = 1'b0;
      m1_wbd_err_o  = 1'b0;

      case (state_q)
         G0: begin
            s_wbd_dat_o   = m0_wbd_dat_i;
            s_wbd_adr_o   = m0_wbd_adr_i;
            s_wbd_sel_o   = m0_wbd_sel_i;
            s_wbd_we_o    = m0_wbd_we_i;
            s_wbd_bl_o    = C_BL_ONE;
            s_wbd_bry_o   = 1'b1;
            s_wbd_cyc_o   = m0_wbd_cyc_i & ~m0_bad;
            s_wbd_stb_o   = m0_wbd_stb_i & ~m0_bad;
            m0_wbd_dat_o  = s_wbd_dat_i;
            // Single-beat master: every ack is also its last ack.
            m0_wbd_ack_o  = s_wbd_ack_i & m0_wbd_stb_i & ~m0_bad;
            m0_wbd_lack_o = s_wbd_ack_i & m0_wbd_stb_i & ~m0_bad;
            m0_wbd_err_o  = m0_wbd_stb_i & m0_bad;
         end
         G1: begin
            s_wbd_dat_o   = m1_wbd_dat_i;
            s_wbd_adr_o   = m1_wbd_adr_i;
            s_wbd_sel_o   = m1_wbd_sel_i;
            s_wbd_we_o    = m1_wbd_we_i;
            s_wbd_bl_o    = m1_wbd_bl_i;
            s_wbd_bry_o   = m1_wbd_bry_i;
            s_wbd_cyc_o   = m1_wbd_cyc_i & ~m1_bad;
            s_wbd_stb_o   = m1_wbd_stb_i & ~m1_bad;
            m1_wbd_dat_o  = s_wbd_dat_i;
            m1_wbd_ack_o  = s_wbd_ack_i  & m1_wbd_stb_i & ~m1_bad;
            m1_wbd_lack_o = s_wbd_lack_i & m1_wbd_stb_i & ~m1_bad;
            m1_wbd_err_o  = m1_wbd_stb_i & m1_bad;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_arb2_slv1.sv
// ----------------------------------------------------------------------------
// tb_wb_arb2_slv1 : directed self-checking bench for the two-master arbiter
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wb_arb2_slv1;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int BLW = 10;

   logic clk = 1'b0;
   logic rst;

   logic [DW-1:0]   m0_dat_i, m0_dat_o;
   logic [AW-1:0]   m0_adr_i;
   logic [DW/8-1:0] m0_sel_i;
   logic            m0_we_i, m0_cyc_i, m0_stb_i;
   logic            m0_ack_o, m0_lack_o, m0_err_o;

   logic [DW-1:0]   m1_dat_i, m1_dat_o;
   logic [AW-1:0]   m1_adr_i;
   logic [DW/8-1:0] m1_sel_i;
   logic [BLW-1:0]  m1_bl_i;
   logic            m1_bry_i, m1_we_i, m1_cyc_i, m1_stb_i;
   logic            m1_ack_o, m1_lack_o, m1_err_o;

   logic [DW-1:0]   s_dat_i, s_dat_o;
   logic            s_ack_i, s_lack_i;
   logic [AW-1:0]   s_adr_o;
   logic [DW/8-1:0] s_sel_o;
   logic [BLW-1:0]  s_bl_o;
   logic            s_bry_o, s_we_o, s_cyc_o, s_stb_o;

   int errors = 0;
   int checks = 0;
   int ack_cnt;
   int lack_cnt;

   always #5 clk = ~clk;

   wb_arb2_slv1 #(.AW(AW), .DW(DW), .BLW(BLW), .SLV_SIZE(262144)) dut (
      .clk           (clk),
      .rst           (rst),
      .m0_wbd_dat_i  (m0_dat_i),
      .m0_wbd_adr_i  (m0_adr_i),
      .m0_wbd_sel_i  (m0_sel_i),
      .m0_wbd_we_i   (m0_we_i),
      .m0_wbd_cyc_i  (m0_cyc_i),
      .m0_wbd_stb_i  (m0_stb_i),
      .m0_wbd_dat_o  (m0_dat_o),
      .m0_wbd_ack_o  (m0_ack_o),
      .m0_wbd_lack_o (m0_lack_o),
      .m0_wbd_err_o  (m0_err_o),
      .m1_wbd_dat_i  (m1_dat_i),
      .m1_wbd_adr_i  (m1_adr_i),
      .m1_wbd_sel_i  (m1_sel_i),
      .m1_wbd_bl_i   (m1_bl_i),
      .m1_wbd_bry_i  (m1_bry_i),
      .m1_wbd_we_i   (m1_we_i),
      .m1_wbd_cyc_i  (m1_cyc_i),
      .m1_wbd_stb_i  (m1_stb_i),
      .m1_wbd_dat_o  (m1_dat_o),
      .m1_wbd_ack_o  (m1_ack_o),
      .m1_wbd_lack_o (m1_lack_o),
      .m1_wbd_err_o  (m1_err_o),
      .s_wbd_dat_i   (s_dat_i),
      .s_wbd_ack_i   (s_ack_i),
      .s_wbd_lack_i  (s_lack_i),
      .s_wbd_dat_o   (s_dat_o),
      .s_wbd_adr_o   (s_adr_o),
      .s_wbd_sel_o   (s_sel_o),
      .s_wbd_bl_o    (s_bl_o),
      .s_wbd_bry_o   (s_bry_o),
      .s_wbd_we_o    (s_we_o),
      .s_wbd_cyc_o   (s_cyc_o),
      .s_wbd_stb_o   (s_stb_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; checks happen 1 ns later still.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1;
      m0_dat_i = '0; m0_adr_i = 32'h500; m0_sel_i = 4'hF; m0_we_i = 1'b1;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      m1_dat_i = '0; m1_adr_i = 32'h600; m1_sel_i = 4'hF; m1_bl_i = 10'd4;
      m1_bry_i = 1'b1; m1_we_i = 1'b0; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      s_dat_i = 32'hDEAD; s_ack_i = 1'b1; s_lack_i = 1'b1;

      // Reset held with both masters requesting and slave acking.
      repeat (3) tick();
      settle();
      check("rst_s_cyc", {63'd0, s_cyc_o}, 64'd0);
      check("rst_s_stb", {63'd0, s_stb_o}, 64'd0);
      check("rst_s_adr", {32'd0, s_adr_o}, 64'd0);
      check("rst_s_bl",  {54'd0, s_bl_o},  64'd0);
      check("rst_acks",  {60'd0, m0_ack_o, m0_lack_o, m1_ack_o, m1_lack_o}, 64'd0);
      check("rst_dat",   {m0_dat_o, m1_dat_o}, 64'd0);
      check("rst_err",   {62'd0, m0_err_o, m1_err_o}, 64'd0);

      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      s_ack_i = 1'b0; s_lack_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // m0 single write, with the one-cycle arbitration delay.
      m0_adr_i = 32'h1000; m0_dat_i = 32'h1; m0_we_i = 1'b1; m0_sel_i = 4'hF;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      settle();
      check("wr_arb_lat_cyc", {63'd0, s_cyc_o}, 64'd0);
      tick();
      check("wr_s_adr", {32'd0, s_adr_o}, 64'h1000);
      check("wr_s_dat", {32'd0, s_dat_o}, 64'h1);
      check("wr_s_ctl", {56'd0, s_we_o, s_cyc_o, s_stb_o, s_bry_o, s_sel_o}, 64'hFF);
      check("wr_s_bl",  {54'd0, s_bl_o}, 64'd1);
      check("wr_no_ack_yet", {63'd0, m0_ack_o}, 64'd0);
      s_ack_i = 1'b1;
      settle();
      check("wr_m0_ack_lack", {62'd0, m0_ack_o, m0_lack_o}, 64'h3);
      check("wr_m1_quiet", {62'd0, m1_ack_o, m1_lack_o}, 64'd0);
      tick();
      s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
      tick();
      check("wr_back_idle", {63'd0, s_cyc_o}, 64'd0);

      // Simultaneous request: m0 wins, m1 follows with no idle gap.
      m0_adr_i = 32'h2000; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      m1_adr_i = 32'h3000; m1_bl_i = 10'd4; m1_bry_i = 1'b1; m1_we_i = 1'b0;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      check("sim_m0_first", {32'd0, s_adr_o}, 64'h2000);
      s_ack_i = 1'b1; s_dat_i = 32'h55;
      settle();
      check("sim_m0_ack", {62'd0, m0_ack_o, m1_ack_o}, 64'h2);
      check("sim_m1_dat0", {32'd0, m1_dat_o}, 64'd0);
      tick();
      s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      tick();
      check("sim_handover_adr", {32'd0, s_adr_o}, 64'h3000);
      check("sim_handover_cyc", {63'd0, s_cyc_o}, 64'd1);
      check("sim_m1_bl", {54'd0, s_bl_o}, 64'd4);

      // m1 burst of 4 beats; m0 asks mid-burst and must wait.
      ack_cnt = 0; lack_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         s_dat_i = 32'hA0 + 32'(i); s_ack_i = 1'b1; s_lack_i = (i == 3);
         settle();
         check("burst_dat", {32'd0, m1_dat_o}, 64'hA0 + 64'(i));
         check("burst_m0_held", {63'd0, m0_ack_o}, 64'd0);
         if (i > 0) check("burst_adr_m1", {32'd0, s_adr_o}, 64'h3000);
         if (m1_ack_o)  ack_cnt++;
         if (m1_lack_o) lack_cnt++;
         tick();
         if (i == 0) begin
            m0_adr_i = 32'h2004; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
         end
      end
      check("burst_ack_cnt",  64'(ack_cnt),  64'd4);
      check("burst_lack_cnt", 64'(lack_cnt), 64'd1);
      s_ack_i = 1'b0; s_lack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      tick();
      check("after_burst_m0", {32'd0, s_adr_o}, 64'h2004);
      check("after_burst_bl", {54'd0, s_bl_o}, 64'd1);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      tick();

      // Decode error just past the window, then the last valid word.
      m0_adr_i = 32'h40000; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      tick();
      s_ack_i = 1'b1;
      settle();
      check("dec_s_cyc_stb", {62'd0, s_cyc_o, s_stb_o}, 64'd0);
      check("dec_err", {63'd0, m0_err_o}, 64'd1);
      check("dec_no_ack", {62'd0, m0_ack_o, m0_lack_o}, 64'd0);
      s_ack_i = 1'b0; m0_stb_i = 1'b0;
      settle();
      check("dec_err_stb0", {63'd0, m0_err_o}, 64'd0);
      m0_adr_i = 32'h3FFFC; m0_stb_i = 1'b1;
      settle();
      check("dec_edge_cyc", {61'd0, s_cyc_o, s_stb_o, m0_err_o}, 64'h6);
      s_ack_i = 1'b1;
      settle();
      check("dec_edge_ack", {63'd0, m0_ack_o}, 64'd1);
      tick();
      s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      tick();

      // Spurious slave ack while idle is dropped.
      s_ack_i = 1'b1; s_lack_i = 1'b1;
      settle();
      check("idle_spurious", {60'd0, m0_ack_o, m0_lack_o, m1_ack_o, m1_lack_o}, 64'd0);
      s_ack_i = 1'b0; s_lack_i = 1'b0;

      // Reset in the middle of an m1 burst.
      m1_adr_i = 32'h100; m1_bl_i = 10'd4; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      check("mid_g1_cyc", {63'd0, s_cyc_o}, 64'd1);
      rst = 1'b1;
      tick();
      check("mid_rst_cyc", {62'd0, s_cyc_o, s_stb_o}, 64'd0);
      check("mid_rst_adr_bl", {22'd0, s_adr_o, s_bl_o}, 64'd0);
      rst = 1'b0;
      settle();
      check("mid_rst_idle", {63'd0, s_cyc_o}, 64'd0);
      tick();
      check("mid_regrant", {63'd0, s_cyc_o}, 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
